// File: rtl/la_capture_if.sv
// la_capture_if: signal bundle between a logic-analyser capture buffer and
// its environment.
//   data     - sample bus from the signal generator
//   trigger  - trigger event, sampled every clock
//   primed   - pre-trigger history is full and a trigger will be accepted
//   rd_en    - readout request, one sample per asserted cycle
//   rd_data  - readout sample
//   rd_valid - rd_data carries a new sample this cycle
//   done     - capture complete, buffer frozen for readout
//   rearm    - restart capture
// master: the environment (generator/reader); slave: the capture block.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface la_capture_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] data;
    logic                  trigger;
    logic                  primed;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  done;
    logic                  rearm;

    modport master (
        output data, trigger, rd_en, rearm,
        input  primed, rd_data, rd_valid, done
    );

    modport slave (
        input  data, trigger, rd_en, rearm,
        output primed, rd_data, rd_valid, done
    );
endinterface

// File: rtl/la_capture.sv
// la_capture: trigger-centred capture buffer for a logic analyser.
// Samples are written circularly into a DEPTH-entry buffer. Once PRE_TRIG
// samples of history exist the block is primed; a trigger then freezes a
// window of PRE_TRIG samples before the trigger, the trigger sample and
// DEPTH-PRE_TRIG-1 samples after it, which can be read out oldest first.
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - la_capture_if.slave (data/trigger/rearm/rd_en in,
//           primed/done/rd_data/rd_valid out)
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module la_capture #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int PRE_TRIG   = 4
) (
    input  logic         clk,
    input  logic         reset,
    la_capture_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;

    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 2);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);
    localparam logic [AW:0]   RD_TOTAL  = AW1'(DEPTH);

    typedef enum logic [1:0] {FILL, ARMED, POST, DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         trig_ptr;
    logic [AW-1:0]         pre_cnt;
    logic [AW-1:0]         post_cnt;
    logic [AW:0]           rd_cnt;

    logic                  wr_en;
    logic                  trig_hit;
    logic                  rd_fire;
    logic                  done_entry;

    logic                  primed_q;
    logic                  done_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FILL;
        else        state <= state_nxt;
    end

    // Next state and per-cycle strobes; rearm overrides everything else,
    // so a coincident trigger or readout request is dropped.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        trig_hit  = 1'b0;
        rd_fire   = 1'b0;
        if (bus.rearm) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL: begin
                    wr_en = 1'b1;
                    if (pre_cnt == PRE_LAST) state_nxt = ARMED;
                end
                ARMED: begin
                    wr_en = 1'b1;
                    if (bus.trigger) begin
                        trig_hit  = 1'b1;
                        state_nxt = POST;
                    end
                end
                POST: begin
                    wr_en = 1'b1;
                    if (post_cnt == POST_LAST) state_nxt = DONE;
                end
                DONE: begin
                    rd_fire = bus.rd_en && (rd_cnt < RD_TOTAL);
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    assign done_entry = (state == POST) && (state_nxt == DONE);

    // Sample buffer: contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.data;
    end

    // Pointers and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            trig_ptr <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            rd_cnt   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (bus.rearm) begin
                pre_cnt <= '0;
                rd_cnt  <= '0;
            end else begin
                if (state == FILL) pre_cnt <= pre_cnt + 1'b1;
                if (trig_hit) begin
                    trig_ptr <= wr_ptr;
                    post_cnt <= '0;
                end else if (state == POST) begin
                    post_cnt <= post_cnt + 1'b1;
                end
                // Oldest retained sample sits PRE_TRIG slots behind the trigger
                if (done_entry) begin
                    rd_ptr <= trig_ptr - PRE_OFS;
                    rd_cnt <= '0;
                end else if (rd_fire) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    // Registered status and readout outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            primed_q   <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            primed_q   <= (state_nxt == ARMED);
            done_q     <= (state_nxt == DONE);
            rd_valid_q <= rd_fire;
            if (rd_fire) rd_data_q <= mem[rd_ptr];
        end
    end

    assign bus.primed   = primed_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule
